// File: rtl/connect4_pkg.sv
// Shared Connect-4 types: board geometry, winner codes and
// the turn sequencer's state encoding.
package connect4_pkg;

  localparam int ROWS = 6;
  localparam int COLS = 7;

  typedef logic [ROWS-1:0][COLS-1:0] board_t;

  typedef enum logic [1:0] {
    NONE,
    P1,
    P2,
    DRAW
  } winner_t;

  typedef enum logic [3:0] {
    IDLE,
    HUMAN_WAIT,
    AI_REQ,
    AI_WAIT,
    DROP,
    CHK_REQ,
    CHK_WAIT,
    SWAP,
    GAME_OVER
  } turn_state_t;

endpackage

// File: rtl/column_drop.sv
// Finds where a piece would land in a column and whether
// the column can take another piece at all.
module column_drop
  import connect4_pkg::*;
(
  input  board_t     occ,
  input  logic [2:0] col,
  output logic [2:0] row,
  output logic       full
);

  logic [ROWS-1:0] bits;

  // Out-of-range columns read as solid, so they report full.
  always_comb begin
    bits = '1;
    for (int c = 0; c < COLS; c++) begin
      if (col == 3'(c)) begin
        for (int r = 0; r < ROWS; r++) begin
          bits[r] = occ[r][c];
        end
      end
    end
  end

  always_comb begin
    row = '0;
    for (int r = 0; r < ROWS; r++) begin
      if (!bits[r]) row = 3'(r);
    end
  end

  assign full = bits[0];

endmodule

// File: rtl/game_turn_controller.sv
// Connect-4 turn sequencer: human/AI turns, piece drops,
// win-checker handshake and win/draw declaration.
module game_turn_controller
  import connect4_pkg::*;
#(
  parameter int TURN_TIMEOUT = 500_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_game,
  input  logic [2:0] col_sel,
  input  logic       col_valid,
  output logic       ai_start,
  output board_t     ai_board,
  input  logic [2:0] ai_col,
  input  logic       ai_done,
  output logic       chk_start,
  output board_t     chk_board,
  input  logic       chk_done,
  input  logic       chk_win,
  output board_t     p1_board,
  output board_t     p2_board,
  output logic       cur_player,
  output logic       illegal_move,
  output logic       turn_timeout,
  output logic       game_over,
  output logic [1:0] winner
);

  localparam int TW =
    (TURN_TIMEOUT > 1) ? $clog2(TURN_TIMEOUT) : 1;
  localparam logic [TW-1:0] T_LAST =
    TW'(TURN_TIMEOUT - 1);

  turn_state_t   state, state_n;
  board_t        p1_q, p2_q, occ;
  logic [2:0]    col_q, cd_col, cd_row;
  logic          cd_full;
  logic          player_q;
  winner_t       win_q, win_n;
  logic [TW-1:0] timer;
  logic          ill_q, ill_n;
  logic          to_q, to_n;
  logic          clr, col_ld, drop, win_ld, swap;

  assign occ = p1_q | p2_q;

  // One drop finder serves the legality checks and DROP.
  always_comb begin
    unique case (1'b1)
      (state == HUMAN_WAIT): cd_col = col_sel;
      (state == AI_WAIT):    cd_col = ai_col;
      default:               cd_col = col_q;
    endcase
  end

  column_drop u_drop (
    .occ  (occ),
    .col  (cd_col),
    .row  (cd_row),
    .full (cd_full)
  );

  always_comb begin
    state_n = state;
    ill_n   = 1'b0;
    to_n    = 1'b0;
    clr     = 1'b0;
    col_ld  = 1'b0;
    drop    = 1'b0;
    win_ld  = 1'b0;
    win_n   = NONE;
    swap    = 1'b0;
    case (state)
      IDLE, GAME_OVER: begin
        if (start_game) begin
          clr     = 1'b1;
          state_n = HUMAN_WAIT;
        end
      end
      HUMAN_WAIT: begin
        if (col_valid && !cd_full) begin
          col_ld  = 1'b1;
          state_n = DROP;
        end else begin
          ill_n = col_valid;
          if (timer == T_LAST) begin
            to_n    = 1'b1;
            state_n = AI_REQ;
          end
        end
      end
      AI_REQ: state_n = AI_WAIT;
      AI_WAIT: begin
        if (ai_done) begin
          if (cd_full) begin
            state_n = AI_REQ;
          end else begin
            col_ld  = 1'b1;
            state_n = DROP;
          end
        end
      end
      DROP: begin
        drop    = 1'b1;
        state_n = CHK_REQ;
      end
      CHK_REQ: state_n = CHK_WAIT;
      CHK_WAIT: begin
        if (chk_done) begin
          if (chk_win) begin
            win_ld  = 1'b1;
            win_n   = player_q ? P2 : P1;
            state_n = GAME_OVER;
          end else if (&occ[0]) begin
            win_ld  = 1'b1;
            win_n   = DRAW;
            state_n = GAME_OVER;
          end else begin
            state_n = SWAP;
          end
        end
      end
      SWAP: begin
        swap    = 1'b1;
        state_n = player_q ? HUMAN_WAIT : AI_REQ;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      p1_q     <= '0;
      p2_q     <= '0;
      col_q    <= '0;
      player_q <= 1'b0;
      win_q    <= NONE;
      timer    <= '0;
      ill_q    <= 1'b0;
      to_q     <= 1'b0;
    end else begin
      state <= state_n;
      ill_q <= ill_n;
      to_q  <= to_n;
      timer <= (state == HUMAN_WAIT) ?
               timer + 1'b1 : '0;
      if (col_ld) col_q <= cd_col;
      if (clr) begin
        p1_q     <= '0;
        p2_q     <= '0;
        player_q <= 1'b0;
        win_q    <= NONE;
      end else begin
        if (drop) begin
          if (player_q) p2_q[cd_row][col_q] <= 1'b1;
          else          p1_q[cd_row][col_q] <= 1'b1;
        end
        if (swap)   player_q <= ~player_q;
        if (win_ld) win_q    <= win_n;
      end
    end
  end

  assign ai_start     = (state == AI_REQ);
  assign chk_start    = (state == CHK_REQ);
  assign game_over    = (state == GAME_OVER);
  assign ai_board     = occ;
  assign chk_board    = player_q ? p2_q : p1_q;
  assign p1_board     = p1_q;
  assign p2_board     = p2_q;
  assign cur_player   = player_q;
  assign illegal_move = ill_q;
  assign turn_timeout = to_q;
  assign winner       = win_q;

endmodule

// File: tb/tb_game_turn_controller.sv
// Randomized Connect-4 games against a grid model, with an
// event scoreboard checked by an independent monitor.
module tb_game_turn_controller;
  import connect4_pkg::*;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start_game = 1'b0;
  logic [2:0] col_sel = '0;
  logic       col_valid = 1'b0;
  logic [2:0] ai_col = '0;
  logic       ai_done = 1'b0;
  logic       chk_done = 1'b0;
  logic       chk_win = 1'b0;
  logic       ai_start, chk_start, cur_player;
  logic       illegal_move, turn_timeout, game_over;
  logic [1:0] winner;
  board_t     ai_board, chk_board, p1_board, p2_board;

  game_turn_controller #(.TURN_TIMEOUT(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .start_game   (start_game),
    .col_sel      (col_sel),
    .col_valid    (col_valid),
    .ai_start     (ai_start),
    .ai_board     (ai_board),
    .ai_col       (ai_col),
    .ai_done      (ai_done),
    .chk_start    (chk_start),
    .chk_board    (chk_board),
    .chk_done     (chk_done),
    .chk_win      (chk_win),
    .p1_board     (p1_board),
    .p2_board     (p2_board),
    .cur_player   (cur_player),
    .illegal_move (illegal_move),
    .turn_timeout (turn_timeout),
    .game_over    (game_over),
    .winner       (winner)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_ILL, EV_TO, EV_AI, EV_CHK, EV_GO} ev_k;
  typedef struct {
    ev_k    k;
    board_t b1;
    board_t b2;
    int     v;
  } ev_t;

  ev_t q[$];
  int  n_tot = 0;
  int  n_pass = 0;
  int  g[ROWS][COLS];
  int  mv = 0;
  bit  done = 0;
  int  force_win = 0;
  int  ai_script[$];
  int  ill_script[$];
  bit  go_q = 0;

  task automatic check(string name, bit ok,
                       logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h want %0h", name, act, exp);
  endtask

  function automatic board_t bd(int p);
    board_t b = '0;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (g[r][c] != 0 && (p == 0 || g[r][c] == p))
          b[r][c] = 1'b1;
    return b;
  endfunction

  function automatic bit full_col(int c);
    return (c > 6) || (g[0][c] != 0);
  endfunction

  function automatic bit top_full();
    for (int c = 0; c < COLS; c++)
      if (g[0][c] == 0) return 0;
    return 1;
  endfunction

  function automatic void put(int c, int p);
    for (int r = ROWS - 1; r >= 0; r--)
      if (g[r][c] == 0) begin
        g[r][c] = p;
        return;
      end
  endfunction

  function automatic bit has_win(int p);
    int dr[4] = '{0, 1, 1, 1};
    int dc[4] = '{1, 0, 1, -1};
    int rr, cc, k;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        for (int d = 0; d < 4; d++) begin
          for (k = 0; k < 4; k++) begin
            rr = r + dr[d] * k;
            cc = c + dc[d] * k;
            if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) break;
            if (g[rr][cc] != p) break;
          end
          if (k == 4) return 1;
        end
    return 0;
  endfunction

  function automatic void push(ev_k k, board_t b1,
                               board_t b2, int v);
    ev_t e;
    e.k = k; e.b1 = b1; e.b2 = b2; e.v = v;
    q.push_back(e);
  endfunction

  task automatic pop_cmp(ev_k k);
    ev_t e;
    if (q.size() == 0) begin
      check("unexpected_event", 0, 64'(k), 64'hff);
      return;
    end
    e = q.pop_front();
    case (k)
      EV_ILL: check("illegal_move",
        e.k == k && p1_board == e.b1 && p2_board == e.b2 &&
        cur_player == e.v[0],
        64'(p1_board | p2_board), 64'(e.b1 | e.b2));
      EV_TO: check("turn_timeout",
        e.k == k && cur_player == e.v[0],
        64'(cur_player), 64'(e.v));
      EV_AI: check("ai_start",
        e.k == k && ai_board == e.b1 && cur_player == e.v[0],
        64'(ai_board), 64'(e.b1));
      EV_CHK: check("chk_start",
        e.k == k && chk_board == e.b1 && cur_player == e.v[0],
        64'(chk_board), 64'(e.b1));
      default: check("game_over",
        e.k == k && winner == e.v[1:0] &&
        p1_board == e.b1 && p2_board == e.b2,
        64'(winner), 64'(e.v));
    endcase
  endtask

  always @(negedge clk) begin
    if (illegal_move) pop_cmp(EV_ILL);
    if (turn_timeout) pop_cmp(EV_TO);
    if (ai_start)     pop_cmp(EV_AI);
    if (chk_start)    pop_cmp(EV_CHK);
    if (game_over && !go_q) pop_cmp(EV_GO);
    go_q = game_over;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic bit sig(int w);
    case (w)
      0:       return ai_start;
      1:       return chk_start;
      default: return turn_timeout;
    endcase
  endfunction

  task automatic wait_for(int w, int exp_n, string name);
    int n = 0;
    while (!sig(w) && n < 60) begin
      tick();
      n++;
    end
    check(name, sig(w) && n == exp_n, 64'(n), 64'(exp_n));
  endtask

  task automatic reply();
    bit w;
    tick();
    repeat ($urandom_range(0, 2)) tick();
    if (force_win == 1)      w = 1;
    else if (force_win == 2) w = 0;
    else                     w = has_win(mv + 1);
    chk_win = w;
    chk_done = 1'b1;
    tick();
    chk_done = 1'b0;
    chk_win = 1'b0;
    if (w || top_full()) begin
      push(EV_GO, bd(1), bd(2), w ? mv + 1 : 3);
      done = 1;
    end else begin
      mv = 1 - mv;
      if (mv == 1) begin
        push(EV_AI, bd(0), '0, 1);
        wait_for(0, 1, "swap_to_ai");
      end else begin
        tick();
      end
    end
  endtask

  task automatic drive_col(int c);
    col_sel = 3'(c);
    col_valid = 1'b1;
    tick();
    col_valid = 1'b0;
  endtask

  task automatic illegal_try();
    int fl[$];
    int c;
    if (ill_script.size() != 0) begin
      c = ill_script.pop_front();
    end else begin
      for (int i = 0; i < COLS; i++)
        if (full_col(i)) fl.push_back(i);
      fl.push_back(7);
      c = fl[$urandom_range(0, fl.size() - 1)];
    end
    push(EV_ILL, bd(1), bd(2), 0);
    drive_col(c);
  endtask

  task automatic human_move(int c, int dly, int n_ill);
    repeat (dly) tick();
    repeat (n_ill) illegal_try();
    put(c, 1);
    push(EV_CHK, bd(1), '0, 0);
    drive_col(c);
    wait_for(1, 1, "human_chk_latency");
    reply();
  endtask

  task automatic noise();
    col_sel = 3'($urandom_range(0, 6));
    case ($urandom_range(0, 3))
      0: start_game = 1'b1;
      1: col_valid = 1'b1;
      2: chk_done = 1'b1;
      default: ;
    endcase
    tick();
    start_game = 1'b0;
    col_valid = 1'b0;
    chk_done = 1'b0;
  endtask

  task automatic ai_move();
    int c;
    for (int t = 0; t < 30; t++) begin
      tick();
      repeat ($urandom_range(0, 3)) noise();
      if (ai_script.size() != 0) begin
        c = ai_script.pop_front();
      end else begin
        c = $urandom_range(0, 7);
        if (t > 5)
          while (full_col(c)) c = $urandom_range(0, 6);
      end
      ai_col = 3'(c);
      if (full_col(c)) begin
        push(EV_AI, bd(0), '0, mv);
        ai_done = 1'b1;
        tick();
        ai_done = 1'b0;
        wait_for(0, 0, "ai_rerequest");
      end else begin
        put(c, mv + 1);
        push(EV_CHK, bd(mv + 1), '0, mv);
        ai_done = 1'b1;
        tick();
        ai_done = 1'b0;
        wait_for(1, 1, "ai_chk_latency");
        reply();
        return;
      end
    end
  endtask

  task automatic human_timeout(int n_ill);
    int n = 0;
    repeat (n_ill) begin
      illegal_try();
      n++;
    end
    push(EV_TO, bd(1), bd(2), 0);
    push(EV_AI, bd(0), '0, 0);
    while (!turn_timeout && n < 60) begin
      tick();
      n++;
    end
    check("timeout_cycles", turn_timeout && n == TO,
          64'(n), 64'(TO));
    ai_move();
  endtask

  function automatic int rnd_legal();
    int c;
    c = $urandom_range(0, 6);
    while (full_col(c)) c = $urandom_range(0, 6);
    return c;
  endfunction

  task automatic new_game();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        g[r][c] = 0;
    mv = 0;
    done = 0;
    start_game = 1'b1;
    tick();
    start_game = 1'b0;
  endtask

  task automatic play_random();
    new_game();
    for (int m = 0; m < 60 && !done; m++) begin
      if (mv == 1)
        ai_move();
      else if ($urandom_range(0, 7) == 0)
        human_timeout($urandom_range(0, 2));
      else
        human_move(rnd_legal(), $urandom_range(0, 8),
                   $urandom_range(0, 3));
    end
  endtask

  task automatic check_all_zero(string name);
    check({name, "_pulses"},
      {ai_start, chk_start, illegal_move,
       turn_timeout, game_over} == 5'b0,
      64'({ai_start, chk_start, illegal_move,
           turn_timeout, game_over}), 64'h0);
    check({name, "_state"}, winner == 2'd0 && cur_player == 0,
      64'({winner, cur_player}), 64'h0);
    check({name, "_boards"},
      p1_board == '0 && p2_board == '0 &&
      ai_board == '0 && chk_board == '0,
      64'(p1_board | p2_board), 64'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();

    force_win = 0;
    new_game();
    human_move(3, 0, 0);
    check("basic_p1_5_3", p1_board[5][3] == 1'b1,
          64'(p1_board), 64'(bd(1)));
    check("basic_cur_player", cur_player == 1'b1,
          64'(cur_player), 64'h1);
    ai_script.push_back(0);
    ai_move();
    human_move(0, 1, 0);
    ai_script.push_back(0);
    ai_move();
    human_move(0, 2, 0);
    ai_script.push_back(0);
    ai_move();
    human_move(0, 0, 0);
    ai_script.push_back(5);
    ai_move();
    ill_script.push_back(0);
    ill_script.push_back(7);
    human_move(4, 1, 2);
    force_win = 1;
    ai_script.push_back(0);
    ai_script.push_back(2);
    ai_move();
    force_win = 0;
    tick();
    check("ai_win", game_over && winner == 2'd2,
          64'({game_over, winner}), 64'h6);

    new_game();
    ai_script.push_back(6);
    human_timeout(1);
    check("timeout_p1_5_6", p1_board[5][6] == 1'b1,
          64'(p1_board), 64'(bd(1)));
    ai_move();
    human_move(rnd_legal(), TO - 1, 0);
    tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_all_zero("midrst");
    ai_col = 3'd1;
    ai_done = 1'b1;
    tick();
    ai_done = 1'b0;
    chk_done = 1'b1;
    tick();
    chk_done = 1'b0;
    repeat (5) tick();
    check_all_zero("post_rst");
    check("rst_queue_empty", q.size() == 0,
          64'(q.size()), 64'h0);

    force_win = 2;
    new_game();
    for (int m = 0; m < 42 && !done; m++) begin
      if (mv == 0) begin
        human_move(m / 6, $urandom_range(0, 3), 0);
      end else begin
        ai_script.push_back(m / 6);
        ai_move();
      end
    end
    tick();
    check("draw", game_over && winner == 2'd3,
          64'({game_over, winner}), 64'h7);
    force_win = 0;

    repeat (4) play_random();

    repeat (3) tick();
    check("queue_drained", q.size() == 0,
          64'(q.size()), 64'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/game_turn_controller.md
# game_turn_controller

Sequences a Connect-4 game between a human (player 1) and the AI (player 2) and owns both players' boards. It collects human column choices and drives the `place_random_move` start/done handshake for AI turns, and for human turns that time out. It drops pieces into the board and runs an external win checker. It also declares win or draw. It sits between the input/debounce logic and the VGA renderer.

## Interface
- `TURN_TIMEOUT`, default 500_000_000: human turn length in clk cycles (10 s at 50 MHz); bench uses 20.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-low reset.
- `start_game` in 1: pulse; starts a new game from IDLE or GAME_OVER.
- `col_sel` in 3: human column, 0..6.
- `col_valid` in 1: one-cycle pulse confirming `col_sel`.
- `ai_start` out 1: one-cycle start pulse to `place_random_move`.
- `ai_board` out 6x7: occupancy (p1 | p2); row 0 is the top row.
- `ai_col` in 3: random column; sampled only when `ai_done`=1.
- `ai_done` in 1: random move ready.
- `chk_start` out 1: one-cycle pulse to the win checker.
- `chk_board` out 6x7: board of the player who just moved.
- `chk_done` in 1: checker finished.
- `chk_win` in 1: four-in-a-row found; valid with `chk_done`.
- `p1_board`, `p2_board` out 6x7: per-player boards.
- `cur_player` out 1: 0 = P1, 1 = P2.
- `illegal_move` out 1: pulse when the chosen column is full or out of range.
- `turn_timeout` out 1: pulse when the human timer expires.
- `game_over` out 1: high in GAME_OVER.
- `winner` out 2: 0 none, 1 P1, 2 P2, 3 draw.

## Operation
- **States:** IDLE, HUMAN_WAIT, AI_REQ, AI_WAIT, DROP, CHK_REQ, CHK_WAIT, SWAP, GAME_OVER.
- **IDLE:** `start_game` clears both boards, sets `cur_player`=0 and `winner`=0, then goes to HUMAN_WAIT.
- **HUMAN_WAIT:**
  - The timer clears on entry and increments every cycle.
  - `col_valid` with `col_sel`<=6 and `ai_board[0][col_sel]`=0 latches the column and goes to DROP.
  - Otherwise `col_valid` pulses `illegal_move`, stays in the state and does not reset the timer.
  - When the timer reaches `TURN_TIMEOUT-1` without a legal `col_valid`: pulse `turn_timeout`, go to AI_REQ with the mover still P1.
  - A legal `col_valid` in the expiry cycle wins: the move is taken and there is no timeout.
- **AI_REQ:** `ai_start`=1 for exactly one cycle, then AI_WAIT. `ai_board` is held stable from AI_REQ until `ai_done`.
- **AI_WAIT:**
  - On `ai_done`, latch `ai_col` and go to DROP.
  - If `ai_col`>6 or that column is full, return to AI_REQ (re-request). There is no retry limit.
- **DROP:**
  - Target row is the highest index r with occupancy[r][col]=0.
  - Set that bit in the mover's board only, then go to CHK_REQ.
- **CHK_REQ:** `chk_start`=1 for one cycle, with `chk_board` = mover's updated board. Then CHK_WAIT.
- **CHK_WAIT:** on `chk_done`:
  - `chk_win`=1: `winner` = mover+1, go to GAME_OVER.
  - Else, if all 7 top-row bits of occupancy are set: `winner`=3, go to GAME_OVER.
  - Else go to SWAP.
- **SWAP:**
  - Toggle `cur_player`.
  - Next state is HUMAN_WAIT for P1 and AI_REQ for P2.
- **GAME_OVER:**
  - Boards and `winner` are held and `game_over`=1.
  - `start_game` behaves as in IDLE.
- **Ignored inputs:**
  - `start_game` in any other state.
  - `col_valid` outside HUMAN_WAIT.
  - `ai_done` outside AI_WAIT.
  - `chk_done` outside CHK_WAIT.

## Timing
- **Reset:** `rst`=0 at an edge forces IDLE and clears all registers; this includes mid-handshake.
  - After that edge, every output is 0: `ai_start`, `chk_start`, `illegal_move`, `turn_timeout`, `game_over`, `winner`, `cur_player`, boards.
  - A late `ai_done` or `chk_done` after reset is ignored.
- **Output timing:** all outputs are registered or decoded from state. Pulses are exactly one cycle wide.
- **Human move latency:** `col_valid` sampled at edge N gives:
  - DROP during cycle N..N+1;
  - board updated at edge N+1;
  - `chk_start` high during N+1..N+2.
- **AI move latency:** `ai_done` sampled at edge M gives the board updated at M+1 and `chk_start` at M+1..M+2.
- **Check to next turn:** `chk_done` at edge K gives SWAP at K, then HUMAN_WAIT or AI_REQ from K+1.
  - The AI turn's `ai_start` rises in the cycle after K+1.
- **Timer:** width is $clog2(TURN_TIMEOUT). `turn_timeout` is high in the cycle after the count reaches `TURN_TIMEOUT-1`. With `TURN_TIMEOUT`=20 that is 20 cycles after HUMAN_WAIT entry.

## Structure
- Package `connect4_pkg` holds:
  - ROWS=6 and COLS=7;
  - `board_t` = logic [ROWS-1:0][COLS-1:0];
  - `winner_t` enum (NONE, P1, P2, DRAW);
  - `turn_state_t` enum (the nine states).
- Sub-module `column_drop`: combinational.
  - Inputs: occupancy `board_t` and column.
  - Outputs: `row[2:0]` (lowest empty row) and `full`.
  - Instantiated once; it serves both the legality check and DROP.

## Test plan
- **Basic turn:** reset, `start_game`, `col_valid` with `col_sel`=3 → `p1_board[5][3]`=1; `chk_start` pulses; `chk_done`=1 with `chk_win`=0 → `ai_start` pulses with `cur_player`=1.
- **Illegal move:** column 0 filled (rows 0..5), `col_valid` with `col_sel`=0 → `illegal_move` pulse, state stays HUMAN_WAIT, boards unchanged; `col_sel`=7 → same.
- **Timeout:** `TURN_TIMEOUT`=20 with no input → `turn_timeout` after 20 cycles, then `ai_start`; `ai_done` with `ai_col`=6 → `p1_board[5][6]`=1.
- **AI re-request and win:** `ai_col`=0 on full column 0 → second `ai_start`; then `ai_col`=2 → `p2_board` bit set, `chk_board`=`p2_board`. `chk_win`=1 → `winner`=2, `game_over`=1.
- **Draw:** board with 41 pieces, last legal move fills the top row, `chk_win`=0 → `winner`=3, `game_over`=1.
- **Reset mid-operation:** `rst`=0 during AI_WAIT → all outputs 0 next cycle; a subsequent `ai_done` pulse is ignored and the state stays IDLE.
